// File: rtl/jk_ms_register_bank.sv
// rtl/jk_ms_register_bank.sv - WIDTH-channel master-slave JK register bank with clear, load and optional change counter
//
// Master stage updates on the clk rising edge: clr, then load, then en-gated per-bit JK.
// Slave stage copies the master into q on the clk falling edge.
// Optional feature macro: JK_EVENT_CNT_EN (saturating slave bit-change counter on toggle_cnt).
//
// Ports:
//   clk        in   1      clock; master on posedge, slave on negedge
//   reset_n    in   1      asynchronous active-low reset
//   en         in   1      master update enable (clr/load act regardless)
//   clr        in   1      synchronous clear of master and counter
//   load       in   1      parallel load of master from d
//   d          in   WIDTH  parallel load data
//   j, k       in   WIDTH  per-channel J and K
//   master_q   out  WIDTH  master stage state
//   q          out  WIDTH  slave stage output
//   toggle_cnt out  CNT_W  slave bit-change count (0 when the feature is compiled out)

module jk_ms_register_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] master_q,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] jk_next;

    // Per bit: 10 sets, 01 resets, 11 toggles, 00 holds.
    always_comb begin
        jk_next = (j & ~k) | (j & k & ~master_q) | (~j & ~k & master_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            master_q <= '0;
        end else if (clr) begin
            master_q <= '0;
        end else if (load) begin
            master_q <= d;
        end else if (en) begin
            master_q <= jk_next;
        end
    end

    // Slave samples on the opposite edge, so a toggling master never races through to q.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= master_q;
        end
    end

`ifdef JK_EVENT_CNT_EN
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    // The counter lives in the negedge domain but must read zero right after a
    // posedge clr. A toggle/ack pair carries the clear across the edges: while
    // they differ, a clear is pending, the output reads zero, and the next
    // negedge restarts accumulation from zero.
    logic             clr_tog;
    logic             clr_ack;
    logic             clr_pending;
    logic [CNT_W-1:0] cnt_acc;
    logic [SUM_W-1:0] change_cnt;
    logic [SUM_W-1:0] cnt_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_tog <= 1'b0;
        end else begin
            clr_tog <= clr_tog ^ clr;
        end
    end

    assign clr_pending = clr_tog ^ clr_ack;

    always_comb begin
        change_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            change_cnt = change_cnt + SUM_W'(master_q[i] ^ q[i]);
        end
        cnt_sum = (clr_pending ? '0 : SUM_W'(cnt_acc)) + change_cnt;
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_ack <= 1'b0;
            cnt_acc <= '0;
        end else begin
            clr_ack <= clr_tog;
            cnt_acc <= (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    assign toggle_cnt = clr_pending ? '0 : cnt_acc;
`else
    assign toggle_cnt = '0;
`endif

endmodule
